// File: rtl/uart_apb_sequencer.sv
// APB master for a 16550-style UART: programs the UART after reset, then shares
// the APB port between RX draining (LSR/RBR polling) and round-robin TX requesters.
module uart_apb_sequencer #(
    parameter int          APB_ADDR_WIDTH = 12,
    parameter int          N_REQ          = 2,
    parameter logic [15:0] DIVISOR        = 16'd27,
    parameter logic [7:0]  LCR_CFG        = 8'h03,
    parameter int          TX_BURST       = 16
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic [N_REQ-1:0]          tx_valid_i,
    input  logic [8*N_REQ-1:0]        tx_data_i,
    output logic [N_REQ-1:0]          tx_ready_o,
    output logic [7:0]                rx_data_o,
    output logic                      rx_perr_o,
    output logic                      rx_valid_o,
    input  logic                      rx_ready_i,
    output logic                      init_done_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY
);
    localparam int RRW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW  = $clog2(TX_BURST + 1);
    localparam logic [RRW-1:0] LAST = RRW'(N_REQ - 1);

    localparam logic [1:0] S_CFG  = 2'd0;
    localparam logic [1:0] S_POLL = 2'd1;
    localparam logic [1:0] S_RXRD = 2'd2;
    localparam logic [1:0] S_TXWR = 2'd3;

    logic [1:0]     st, nst;
    logic [2:0]     cfg_step, ncfg;
    logic [CW-1:0]  credit, ncredit;
    logic [RRW-1:0] rr, gnt, idx;
    logic [RRW:0]   sum;
    logic           dr, ndr, pe, npe;
    logic           found, any_valid, done, launch, tx_grant;
    logic [2:0]     cfg_addr, p_addr;
    logic [7:0]     cfg_data, p_data;
    logic           p_write;
    logic           prdata_unused;

    assign prdata_unused = ^PRDATA[31:8];
    assign any_valid     = |tx_valid_i;
    assign done          = PSEL & PENABLE & PREADY;
    // A new SETUP is issued right after reset or in the cycle an ACCESS completes.
    assign launch        = ~PSEL | done;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr} + (RRW+1)'(k);
            if (sum >= (RRW+1)'(N_REQ)) sum = sum - (RRW+1)'(N_REQ);
            idx = sum[RRW-1:0];
            if (!found && tx_valid_i[idx]) begin
                gnt   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        nst     = st;
        ncfg    = cfg_step;
        ncredit = credit;
        ndr     = dr;
        npe     = pe;
        if (done) begin
            case (st)
                S_CFG: begin
                    if (cfg_step == 3'd5) nst = S_POLL;
                    else                  ncfg = cfg_step + 3'd1;
                end
                S_POLL: begin
                    ndr = PRDATA[0];
                    npe = PRDATA[2];
                    if (PRDATA[5]) ncredit = CW'(TX_BURST);
                    if (PRDATA[0] && !rx_valid_o)          nst = S_RXRD;
                    else if (ncredit != '0 && any_valid)   nst = S_TXWR;
                    else                                   nst = S_POLL;
                end
                S_RXRD:  nst = S_POLL;
                default: nst = (credit != '0 && !dr && any_valid) ? S_TXWR : S_POLL;
            endcase
        end
    end

    always_comb begin
        case (ncfg)
            3'd0:    begin cfg_addr = 3'd3; cfg_data = 8'h80 | LCR_CFG; end
            3'd1:    begin cfg_addr = 3'd0; cfg_data = DIVISOR[7:0];    end
            3'd2:    begin cfg_addr = 3'd1; cfg_data = DIVISOR[15:8];   end
            3'd3:    begin cfg_addr = 3'd3; cfg_data = LCR_CFG;         end
            3'd4:    begin cfg_addr = 3'd2; cfg_data = 8'h06;           end
            default: begin cfg_addr = 3'd1; cfg_data = 8'h00;           end
        endcase
    end

    always_comb begin
        p_addr  = 3'd0;
        p_data  = 8'h00;
        p_write = 1'b0;
        case (nst)
            S_CFG:  begin p_addr = cfg_addr; p_data = cfg_data; p_write = 1'b1; end
            S_POLL: p_addr = 3'd5;
            S_RXRD: p_addr = 3'd0;
            default: begin p_data = tx_data_i[{gnt, 3'b000} +: 8]; p_write = 1'b1; end
        endcase
    end

    // The requester byte is consumed in the cycle its THR SETUP is registered.
    assign tx_grant   = launch & (nst == S_TXWR) & found;
    assign tx_ready_o = tx_grant ? (N_REQ'(1) << gnt) : '0;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            st          <= S_CFG;
            cfg_step    <= 3'd0;
            credit      <= '0;
            rr          <= '0;
            dr          <= 1'b0;
            pe          <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            init_done_o <= 1'b0;
            rx_valid_o  <= 1'b0;
            rx_data_o   <= 8'h00;
            rx_perr_o   <= 1'b0;
        end else begin
            st       <= nst;
            cfg_step <= ncfg;
            dr       <= ndr;
            pe       <= npe;
            credit   <= tx_grant ? ncredit - CW'(1) : ncredit;
            if (tx_grant) rr <= (gnt == LAST) ? '0 : gnt + RRW'(1);
            if (launch) begin
                PSEL    <= 1'b1;
                PENABLE <= 1'b0;
                PADDR   <= APB_ADDR_WIDTH'(p_addr);
                PWDATA  <= {24'h0, p_data};
                PWRITE  <= p_write;
            end else begin
                PENABLE <= 1'b1;
            end
            if (done && st == S_CFG && cfg_step == 3'd5) init_done_o <= 1'b1;
            if (done && st == S_RXRD) begin
                rx_valid_o <= 1'b1;
                rx_data_o  <= PRDATA[7:0];
                rx_perr_o  <= pe;
            end else if (rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Scoreboard bench: expected APB writes and RX bytes are queued from stimulus
// and matched as the DUT completes transfers.
module tb_uart_apb_sequencer;
    localparam int N_REQ = 2;

    logic               CLK = 1'b0;
    logic               RSTN = 1'b0;
    logic [N_REQ-1:0]   tx_valid_i = '0;
    logic [8*N_REQ-1:0] tx_data_i = '0;
    logic [N_REQ-1:0]   tx_ready_o;
    logic [7:0]         rx_data_o;
    logic               rx_perr_o, rx_valid_o;
    logic               rx_ready_i = 1'b0;
    logic               init_done_o;
    logic [11:0]        PADDR;
    logic [31:0]        PWDATA;
    logic               PWRITE, PSEL, PENABLE;
    logic [31:0]        PRDATA = '0;
    logic               PREADY = 1'b1;

    uart_apb_sequencer #(.APB_ADDR_WIDTH(12), .N_REQ(N_REQ), .DIVISOR(16'd27),
                         .LCR_CFG(8'h03), .TX_BURST(16)) dut (
        .CLK(CLK), .RSTN(RSTN), .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i),
        .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o), .rx_perr_o(rx_perr_o),
        .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .init_done_o(init_done_o),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [10:0] exp_wr[$];
    logic [8:0]  rx_exp[$];
    logic [7:0]  prod0[$];
    logic [7:0]  prod1[$];
    logic [7:0]  lsr_q[$];
    logic [7:0]  lsr_def = 8'h60;
    logic [7:0]  rbr_val = 8'h00;
    logic [7:0]  last_lsr = 8'h00;
    logic [N_REQ-1:0] hs = '0;
    int burst_cnt = 0;
    int burst_q[$];
    int n_rbr = 0;
    int n65 = 0;
    logic rx_first_pend = 1'b0;

    // Monitor, consumer and APB slave, all sampled mid-cycle.
    always @(negedge CLK) begin
        if (PSEL && PENABLE && PREADY) begin
            if (rx_first_pend) begin
                chk("rx_first", {28'h0, PWRITE, PADDR[2:0]}, 32'h0);
                rx_first_pend = 1'b0;
            end
            if (PWRITE) begin
                if (exp_wr.size() == 0) chk("wr_unexp", exp_wr.size(), 1);
                else chk("apb_wr", {21'h0, PADDR[2:0], PWDATA[7:0]}, {21'h0, exp_wr.pop_front()});
                if (init_done_o && PADDR[2:0] == 3'd0) begin
                    burst_cnt++;
                    if (burst_cnt > 16) chk("burst_max", burst_cnt, 16);
                end
            end else if (PADDR[2:0] == 3'd5) begin
                if (burst_cnt > 0) burst_q.push_back(burst_cnt);
                if (PRDATA[5]) burst_cnt = 0;
                last_lsr = PRDATA[7:0];
                if (PRDATA[7:0] == 8'h65) begin
                    n65++;
                    rx_first_pend = 1'b1;
                end
            end else if (PADDR[2:0] == 3'd0) begin
                n_rbr++;
                rx_exp.push_back({last_lsr[2], PRDATA[7:0]});
            end
        end
        if (tx_ready_o != '0) begin
            chk("rdy_onehot", {31'h0, $onehot(tx_ready_o)}, 32'h1);
            chk("rdy_valid", {30'h0, tx_ready_o & ~tx_valid_i}, 32'h0);
        end
        hs = tx_ready_o & tx_valid_i;
        if (rx_valid_o && rx_ready_i) begin
            if (rx_exp.size() == 0) chk("rx_unexp", rx_exp.size(), 1);
            else chk("rx_byte", {23'h0, rx_perr_o, rx_data_o}, {23'h0, rx_exp.pop_front()});
        end
        if (PSEL && !PENABLE && !PWRITE)
            PRDATA = {24'h0, (PADDR[2:0] == 3'd5) ? ((lsr_q.size() != 0) ? lsr_q.pop_front() : lsr_def)
                                                  : rbr_val};
    end

    // Requesters: pop the byte consumed at the previous edge, present the next.
    always @(posedge CLK) begin
        #1;
        if (hs[0] && prod0.size() != 0) void'(prod0.pop_front());
        if (hs[1] && prod1.size() != 0) void'(prod1.pop_front());
        tx_valid_i = {prod1.size() != 0, prod0.size() != 0};
        tx_data_i  = {(prod1.size() != 0) ? prod1[0] : 8'h00, (prod0.size() != 0) ? prod0[0] : 8'h00};
    end

    task automatic do_reset();
        RSTN = 1'b0;
        #1;
        chk("rst_ctl", {25'h0, PSEL, PENABLE, PWRITE, init_done_o, rx_valid_o, rx_perr_o, tx_ready_o}, 32'h0);
        chk("rst_addr", {20'h0, PADDR}, 32'h0);
        chk("rst_wdata", PWDATA, 32'h0);
        exp_wr.delete(); rx_exp.delete(); prod0.delete(); prod1.delete(); lsr_q.delete();
        burst_q.delete();
        burst_cnt = 0;
        rx_first_pend = 1'b0;
        exp_wr.push_back({3'd3, 8'h83}); exp_wr.push_back({3'd0, 8'h1B});
        exp_wr.push_back({3'd1, 8'h00}); exp_wr.push_back({3'd3, 8'h03});
        exp_wr.push_back({3'd2, 8'h06}); exp_wr.push_back({3'd1, 8'h00});
        @(posedge CLK); #1;
        RSTN = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while (k < 2000 && exp_wr.size() != 0) begin
            @(posedge CLK);
            k++;
        end
        #1;
        chk(tag, exp_wr.size(), 0);
    endtask

    task automatic wait_apb(input string tag, input logic [2:0] a, input logic wr, input logic en);
        int k = 0;
        logic hit = 1'b0;
        while (k < 500 && !hit) begin
            @(posedge CLK); #1;
            hit = PSEL && (PENABLE == en) && (PWRITE == wr) && (PADDR[2:0] == a) && init_done_o;
            k++;
        end
        chk(tag, {31'h0, hit}, 32'h1);
    endtask

    initial begin
        int n0;
        // 1: configuration sequence and init_done timing
        @(posedge CLK); #1;
        do_reset();
        for (int k = 1; k <= 13; k++) begin
            @(posedge CLK); @(negedge CLK);
            if (k == 12) chk("init_lo_c12", {31'h0, init_done_o}, 32'h0);
            if (k == 13) chk("init_hi_c13", {31'h0, init_done_o}, 32'h1);
        end
        chk("cfg_writes", exp_wr.size(), 0);

        // 2: single requester, 20 bytes, credit bursts of 16 then 4
        do_reset();
        for (int i = 0; i < 20; i++) begin
            prod0.push_back(8'h10 + 8'(i));
            exp_wr.push_back({3'd0, 8'h10 + 8'(i)});
        end
        wait_drain("tx20_drain");
        repeat (10) @(posedge CLK);
        #1;
        chk("burst_n", burst_q.size(), 2);
        if (burst_q.size() >= 2) begin
            chk("burst0", burst_q[0], 16);
            chk("burst1", burst_q[1], 4);
        end

        // 3: two requesters continuously valid alternate
        do_reset();
        for (int i = 0; i < 4; i++) begin
            prod0.push_back(8'hA0 + 8'(i));
            prod1.push_back(8'hB0 + 8'(i));
            exp_wr.push_back({3'd0, 8'hA0 + 8'(i)});
            exp_wr.push_back({3'd0, 8'hB0 + 8'(i)});
        end
        wait_drain("rr_drain");

        // 4: RX byte held while consumer stalls; no further RBR read until accepted
        @(posedge CLK); #1;
        lsr_def = 8'h61; rbr_val = 8'h5A; rx_ready_i = 1'b0;
        n0 = n_rbr;
        repeat (40) @(posedge CLK);
        #1;
        chk("rbr_once", n_rbr - n0, 1);
        chk("rx_hold", {23'h0, rx_valid_o, rx_data_o}, 32'h15A);
        lsr_def = 8'h60;
        repeat (4) @(posedge CLK);
        #1;
        rx_ready_i = 1'b1;
        @(posedge CLK); #1;
        rx_ready_i = 1'b0;
        chk("rx_empty", {31'h0, rx_valid_o}, 32'h0);
        lsr_def = 8'h61; rbr_val = 8'h3C;
        repeat (20) @(posedge CLK);
        #1;
        chk("rbr_again", n_rbr - n0, 2);
        lsr_def = 8'h60; rx_ready_i = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        chk("rx_drain4", rx_exp.size(), 0);

        // 5: parity-flagged RX byte served before pending TX
        wait_apb("lsr_setup", 3'd5, 1'b0, 1'b0);
        lsr_q.push_back(8'h65);
        rbr_val = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            prod1.push_back(8'hC0 + 8'(i));
            exp_wr.push_back({3'd0, 8'hC0 + 8'(i)});
        end
        wait_drain("t5_drain");
        repeat (5) @(posedge CLK);
        #1;
        chk("lsr65_seen", n65, 1);
        chk("rx_drain5", rx_exp.size(), 0);

        // 6a: PREADY stall freezes an in-flight THR write
        for (int i = 0; i < 3; i++) begin
            prod0.push_back(8'hD0 + 8'(i));
            exp_wr.push_back({3'd0, 8'hD0 + 8'(i)});
        end
        wait_apb("thr_access", 3'd0, 1'b1, 1'b1);
        PREADY = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("stall_apb", {18'h0, PADDR[2:0], PWDATA[7:0], PSEL, PENABLE, PWRITE},
                {18'h0, 3'd0, 8'hD0, 3'b111});
            chk("stall_rdy", {30'h0, tx_ready_o}, 32'h0);
        end
        @(posedge CLK); #1;
        PREADY = 1'b1;
        wait_drain("t6_drain");

        // 6b: reset in the middle of a THR write restarts configuration
        for (int i = 0; i < 3; i++) begin
            prod0.push_back(8'hE0 + 8'(i));
            exp_wr.push_back({3'd0, 8'hE0 + 8'(i)});
        end
        wait_apb("thr_setup", 3'd0, 1'b1, 1'b0);
        RSTN = 1'b0;
        #1;
        chk("rst_mid", {28'h0, PSEL, PENABLE, init_done_o, rx_valid_o}, 32'h0);
        do_reset();
        wait_drain("recfg_drain");
        repeat (3) @(posedge CLK);
        #1;
        chk("recfg_init", {31'h0, init_done_o}, 32'h1);
        chk("final_rx", rx_exp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
